fft4_seq: RTL
=============

Name: fft4_seq

Overview:
- Sequencer for a 4-point (radix-4) DFT built around one shared butterfly unit: one complex adder, one complex subtractor and one multiply-by-j.
- Collects four complex samples over a valid/ready stream and schedules the butterfly over four compute cycles.
- Streams four results out in natural order X0..X3 over a valid/ready stream.
- Building block for the FFT pipeline stages.

Parameters:
- W, 16, real/imag sample width (two's complement).
- SCALE, 0, 1 = arithmetic shift right by 1 after each butterfly stage (overflow protection); 0 = plain wrap-around.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns the block to LOAD.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_r, in_i  in  W each  input sample, real/imag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts a result.
- out_r, out_i  out  W each  result, real/imag.
- out_idx  out  2  bin index of the current result (0..3).
- out_last  out  1  high with X3.
- busy  out  1  high in CALC or OUT.

Behaviour:
- States and transitions:
  - LOAD: accept samples; go to CALC when the 4th sample is accepted.
  - CALC: 4 cycles; go to OUT after the 4th.
  - OUT: emit 4 results; go to LOAD when X3 is accepted.
  - One 2-bit counter cnt is shared by all states; it clears on every state change.
- Reset: state=LOAD, cnt=0, sample/intermediate registers=0.
  - Reset outputs: in_ready=1, out_valid=0, out_r/out_i=0, out_idx=0, out_last=0, busy=0.
- Reset is effective immediately, including mid-LOAD, mid-CALC and mid-OUT; partial frames are discarded.
- in_ready = (state==LOAD). A sample transfers when in_valid & in_ready; it is stored in x[cnt] and cnt increments.
- CALC schedule (one butterfly use per cycle; sum and difference computed together):
  - cnt0: a = x0+x2, c = x0-x2.
  - cnt1: b = x1+x3, d = x1-x3.
  - cnt2: X0 = a+b, X2 = a-b.
  - cnt3: X1 = c - j·d, X3 = c + j·d, where j·(p,q) = (-q, p).
- Arithmetic:
  - Each sum/difference is formed at W+1 bits.
  - SCALE=0: truncate to the low W bits (wraps).
  - SCALE=1: arithmetic shift right 1, then take W bits.
  - Negation in j-multiply wraps (-(-2^(W-1)) = -2^(W-1)).
- Latency: last input accepted on edge T; CALC occupies edges T+1..T+4; out_valid=1 in the cycle after edge T+4. Minimum frame period is 12 cycles (4 LOAD + 4 CALC + 4 OUT).
- OUT:
  - out_valid = (state==OUT); results are driven in order X0, X1, X2, X3 with out_idx = cnt.
  - A transfer occurs on out_valid & out_ready, then cnt increments.
  - While out_ready=0: out_r, out_i and out_idx hold stable, and out_valid stays high.
  - out_last = out_valid & (cnt==3).
- Input during non-LOAD states: in_ready=0, so there is no transfer.
- flush:
  - Takes priority over any transfer in the same cycle; that sample or result is dropped/not counted.
  - Next cycle: state=LOAD, cnt=0, out_valid=0.
  - Stored samples are not cleared; they are overwritten by the next frame.
- Zero bubbles: after X3 is accepted, in_ready=1 in the next cycle.

Decomposition:
- Shared package fft_pkg:
  - W default constant.
  - State encoding (LOAD, CALC, OUT).
  - Complex sample typedef {r, i}.
- One sub-module, fft4_bfly (combinational), instantiated once:
  - Inputs: p, q, rot_j, SCALE.
  - Output sum = p + (rot_j ? j·q : q).
  - Output dif = p - (rot_j ? j·q : q).
  - Internally uses W+1-bit add/sub, a j-rotate, and optional shift.
- The sequencer drives the operand muxes, rot_j (high only at CALC cnt3) and the destination register enables.

Test Plan:
- Basic, SCALE=0: inputs (1,0),(2,0),(3,0),(4,0) back-to-back → X0=(10,0), X1=(-2,2), X2=(-2,0), X3=(-2,-2); out_idx 0..3; out_last only on X3; first out_valid 5 cycles after the 4th input edge.
- Backpressure: same frame, out_ready low for 3 cycles at X1 → X1 held stable with out_valid=1; no skipped or repeated bins.
- Overflow with 4×(16384,0):
  - SCALE=0 → X0=(0,0) wrapped, X1=X2=X3=(0,0).
  - SCALE=1 → X0=(16384,0), other bins (0,0).
- Imaginary input (0,1),(0,0),(0,0),(0,0) → all four bins (0,1).
- Flush: flush during CALC cnt2 → out_valid stays 0, in_ready=1 next cycle; the following frame (1,0)×4 → X0=(4,0), others (0,0). Also check flush coincident with an in_valid transfer → that sample is not counted.
- Async reset: assert rst_n=0 mid-OUT between clock edges → out_valid drops immediately; after release, in_ready=1 and busy=0; a full new frame is processed correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types for the FFT building blocks: default sample width, sequencer
// state encoding and a complex sample at the default width.
package fft_pkg;

    localparam int FFT_W = 16;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [FFT_W-1:0] r;
        logic signed [FFT_W-1:0] i;
    } cplx_t;

endpackage

// File: rtl/fft4_seq_if.sv
// Sample-in / result-out streams of the 4-point DFT sequencer.
interface fft4_seq_if
    import fft_pkg::*;
#(
    parameter int W = FFT_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_r;
    logic [W-1:0] in_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_r;
    logic [W-1:0] out_i;
    logic [1:0]   out_idx;
    logic         out_last;

    modport master (
        output in_valid, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_r, in_i, out_ready,
        output in_ready, out_valid, out_r, out_i, out_idx, out_last
    );
endinterface

// File: rtl/fft4_bfly.sv
// Shared radix-2 butterfly: sum = p + q', dif = p - q', where q' is q or j*q.
// Arithmetic is W+1 bits wide, then wrapped or halved back to W bits.
module fft4_bfly
    import fft_pkg::*;
#(
    parameter int W     = FFT_W,
    parameter bit SCALE = 1'b0
) (
    input  logic [W-1:0] p_r,
    input  logic [W-1:0] p_i,
    input  logic [W-1:0] q_r,
    input  logic [W-1:0] q_i,
    input  logic         rot_j,
    output logic [W-1:0] sum_r,
    output logic [W-1:0] sum_i,
    output logic [W-1:0] dif_r,
    output logic [W-1:0] dif_i
);

    logic [W-1:0] qr, qi;
    logic [W:0]   sr, si, dr, di;

    function automatic logic [W-1:0] fit(input logic [W:0] v);
        return SCALE ? v[W:1] : v[W-1:0];
    endfunction

    // j*(a,b) = (-b, a); the negation stays at W bits so -min wraps to min.
    always_comb begin
        if (rot_j) begin
            qr = W'(-q_i);
            qi = q_r;
        end else begin
            qr = q_r;
            qi = q_i;
        end
    end

    assign sr = {p_r[W-1], p_r} + {qr[W-1], qr};
    assign si = {p_i[W-1], p_i} + {qi[W-1], qi};
    assign dr = {p_r[W-1], p_r} - {qr[W-1], qr};
    assign di = {p_i[W-1], p_i} - {qi[W-1], qi};

    assign sum_r = fit(sr);
    assign sum_i = fit(si);
    assign dif_r = fit(dr);
    assign dif_i = fit(di);

endmodule

// File: rtl/fft4_seq.sv
// 4-point DFT sequencer: loads four samples, runs the shared butterfly for
// four cycles, then streams X0..X3 out in natural order.
module fft4_seq
    import fft_pkg::*;
#(
    parameter int W     = FFT_W,
    parameter bit SCALE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    output logic       busy,
    fft4_seq_if.slave  s
);

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] i;
    } cx_t;

    state_t     state, next_state;
    logic [1:0] cnt, next_cnt;

    cx_t [3:0]  x;
    cx_t [3:0]  res;
    cx_t        a, b, c, d;
    cx_t        p, q;
    logic       rot_j;
    logic [W-1:0] sum_r, sum_i, dif_r, dif_i;

    logic in_xfer, out_xfer, calc_en;

    assign in_xfer  = s.in_valid & s.in_ready & ~flush;
    assign out_xfer = s.out_valid & s.out_ready & ~flush;
    assign calc_en  = (state == CALC) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            cnt   <= 2'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // cnt is shared by all states and clears on every state change.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        if (flush) begin
            next_state = LOAD;
            next_cnt   = 2'd0;
        end else begin
            case (state)
                LOAD: if (in_xfer) begin
                    if (cnt == 2'd3) begin
                        next_state = CALC;
                        next_cnt   = 2'd0;
                    end else begin
                        next_cnt = cnt + 2'd1;
                    end
                end
                CALC: begin
                    if (cnt == 2'd3) begin
                        next_state = OUT;
                        next_cnt   = 2'd0;
                    end else begin
                        next_cnt = cnt + 2'd1;
                    end
                end
                OUT: if (out_xfer) begin
                    if (cnt == 2'd3) begin
                        next_state = LOAD;
                        next_cnt   = 2'd0;
                    end else begin
                        next_cnt = cnt + 2'd1;
                    end
                end
                default: begin
                    next_state = LOAD;
                    next_cnt   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        s.in_ready  = (state == LOAD);
        s.out_valid = (state == OUT);
        busy        = (state != LOAD);
        s.out_last  = (state == OUT) && (cnt == 2'd3);
        s.out_idx   = (state == OUT) ? cnt : 2'd0;
        s.out_r     = (state == OUT) ? res[cnt].r : '0;
        s.out_i     = (state == OUT) ? res[cnt].i : '0;
        rot_j       = (state == CALC) && (cnt == 2'd3);
        case (cnt)
            2'd0:    begin p = x[0]; q = x[2]; end
            2'd1:    begin p = x[1]; q = x[3]; end
            2'd2:    begin p = a;    q = b;    end
            default: begin p = c;    q = d;    end
        endcase
    end

    fft4_bfly #(.W(W), .SCALE(SCALE)) u_bfly (
        .p_r   (p.r),
        .p_i   (p.i),
        .q_r   (q.r),
        .q_i   (q.i),
        .rot_j (rot_j),
        .sum_r (sum_r),
        .sum_i (sum_i),
        .dif_r (dif_r),
        .dif_i (dif_i)
    );

    // At cnt3 sum = c + j*d lands in X3 and dif = c - j*d lands in X1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '0;
            res <= '0;
            a   <= '0;
            b   <= '0;
            c   <= '0;
            d   <= '0;
        end else begin
            if (in_xfer) begin
                x[cnt] <= {s.in_r, s.in_i};
            end
            if (calc_en) begin
                case (cnt)
                    2'd0: begin a <= {sum_r, sum_i}; c <= {dif_r, dif_i}; end
                    2'd1: begin b <= {sum_r, sum_i}; d <= {dif_r, dif_i}; end
                    2'd2: begin res[0] <= {sum_r, sum_i}; res[2] <= {dif_r, dif_i}; end
                    default: begin res[3] <= {sum_r, sum_i}; res[1] <= {dif_r, dif_i}; end
                endcase
            end
        end
    end

endmodule
